vram_dp: RTL
============

# vram_dp

Dual-port video RAM for the display subsystem. Port A is the CPU/bus side: read/write with byte enables and a ready/valid handshake. Port B is the read-only scan-out side. It has no stall, so the display keeps fetching while memory is being cleared. A built-in clear engine fills the whole array with a programmable value after reset or on request, so software does not have to loop over thousands of words.

## Interface
Parameters:
- DATA_WIDTH, default 16: word width in bits; must be a multiple of 8.
- ADDR_BITS, default 11: address width; depth N = 2**ADDR_BITS.
- CLEAR_ON_RESET, default 1: when 1, a clear starts automatically after reset deasserts.
- RESET_FILL, default 0: fill value used by the automatic post-reset clear.

Ports:
- CLK  in  1  single clock; all logic on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- A_EN  in  1  port A request.
- A_WE  in  1  1 = write, 0 = read.
- A_BE  in  DATA_WIDTH/8  byte enables for writes; bit i covers bits [8i+7:8i].
- A_ADDR  in  ADDR_BITS  port A address.
- A_DIN  in  DATA_WIDTH  port A write data.
- A_READY  out  1  port A can accept a request; equals !BUSY.
- A_DOUT  out  DATA_WIDTH  port A read data.
- A_VALID  out  1  one-cycle pulse when A_DOUT carries a new read result.
- B_EN  in  1  port B read request.
- B_ADDR  in  ADDR_BITS  port B address.
- B_DOUT  out  DATA_WIDTH  port B read data.
- B_VALID  out  1  one-cycle pulse when B_DOUT carries a new read result.
- CLEAR_REQ  in  1  start a clear; sampled only while the engine is IDLE.
- CLEAR_VALUE  in  DATA_WIDTH  fill value, latched when CLEAR_REQ is accepted.
- BUSY  out  1  clear in progress.

## Operation
- **Outputs at reset:** A_DOUT=0, B_DOUT=0, A_VALID=0, B_VALID=0. BUSY=0, so A_READY=1.
  - The array contents are not reset; they are retained.
- **Port A acceptance:** a request is accepted at an edge where A_EN && A_READY.
- **Port A write:** only bytes with A_BE=1 are updated.
  - A_VALID stays 0 and A_DOUT holds its previous value.
  - A_BE=0 on a write is a no-op but still counts as accepted.
- **Port A read:** A_DOUT = mem[A_ADDR] and A_VALID=1.
- **Port A while BUSY:** A_EN is ignored, with no side effects.
- **Port B read:** served every cycle B_EN=1, including during a clear.
- **Same-address collision:** if port A (or the clear engine) writes address X in the same cycle port B reads X, B returns the old data (read-first).
- **Clear FSM states:** IDLE, CLEAR.
  - IDLE→CLEAR on CLEAR_REQ=1, or on the first edge after reset release when CLEAR_ON_RESET=1.
  - Entering CLEAR latches the fill value (CLEAR_VALUE, or RESET_FILL for the post-reset clear) and sets the counter to 0.
  - In CLEAR, each cycle writes the fill value to mem[counter] and increments the counter.
  - When the counter reaches N-1, that write completes and the FSM returns to IDLE.
- **CLEAR_REQ while BUSY:** ignored; it is not queued.
- **CLEAR_REQ and an A request in the same IDLE cycle:** the A access is accepted and completes at that edge, and the clear starts at that same edge.
- **Reset during a clear:** the clear aborts immediately and the counter goes to 0.
  - Memory is left partially filled.
  - The clear restarts from address 0 only if CLEAR_ON_RESET=1.
- **Width rule:** the counter is ADDR_BITS+0 bits wide; termination is detected by compare against N-1, not by overflow.

## Timing
- Read latency, either port: 1 cycle. A request at edge k gives DOUT and VALID after edge k; VALID drops after edge k+1 unless a new read is accepted.
- Back-to-back reads: one per cycle on each port independently, with no bubbles.
- Clear duration: CLEAR_REQ accepted at edge k.
  - BUSY rises after edge k.
  - mem[i] is written at edge k+1+i.
  - BUSY falls after edge k+N, so BUSY is high for exactly N cycles.
- A_READY is combinational from BUSY and has no extra latency.

## Configuration
- Macro `VRAM_DP_OUTREG_EN`.
- **Defined:** both ports gain an output register stage.
  - Read latency becomes 2 cycles; VALID is delayed along with the data.
  - The extra register also resets to 0.
  - Throughput is unchanged at 1 per cycle.
- **Undefined:** latency is 1 cycle, as in Timing.
- The clear-engine cycle counts are identical either way.

## Test plan
- **Reset, post-reset fill:** CLEAR_ON_RESET=1, RESET_FILL=16'h0000, release RESET_N -> BUSY high exactly 2048 cycles; then port A reads of 0x000, 0x3FF and 0x7FF return 0x0000 with A_VALID one cycle later.
- **Byte-enable write:** mem[0x010]=0xFFFF, then write A_DIN=0x1234 with A_BE=2'b01 -> a read returns 0xFF34.
- **Stall during clear:** CLEAR_REQ with CLEAR_VALUE=0xAAAA, then A_EN write to 0x005 while BUSY -> A_READY=0 and the write is dropped; after BUSY falls, mem[0x005]=0xAAAA.
- **Collision:** mem[0x100]=0x1111; same cycle, A writes 0x2222 to 0x100 and B reads 0x100 -> B_DOUT=0x1111; next B read returns 0x2222.
- **Reset mid-clear:** assert RESET_N low at counter 0x200 with CLEAR_ON_RESET=0 -> BUSY=0 and all outputs 0 immediately; mem[0x1FF]=fill value, mem[0x201] unchanged.
- **Output register option:** with `VRAM_DP_OUTREG_EN`, a port B read at edge k -> B_VALID and data after edge k+1; streaming reads of 0..7 return in order with no gaps.

Source files
------------

// File: rtl/vram_dp.sv
// Dual-port video RAM: port A read/write with byte enables, port B read-only scan-out,
// plus a fill engine for the whole array. Optional output register stage: VRAM_DP_OUTREG_EN.
module vram_dp #(
  parameter int unsigned               DATA_WIDTH     = 16,
  parameter int unsigned               ADDR_BITS      = 11,
  parameter bit                        CLEAR_ON_RESET = 1'b1,
  parameter logic [DATA_WIDTH-1:0]     RESET_FILL     = '0
) (
  input  logic                         CLK,
  input  logic                         RESET_N,
  // port A: bus side
  input  logic                         A_EN,
  input  logic                         A_WE,
  input  logic [DATA_WIDTH/8-1:0]      A_BE,
  input  logic [ADDR_BITS-1:0]         A_ADDR,
  input  logic [DATA_WIDTH-1:0]        A_DIN,
  output logic                         A_READY,
  output logic [DATA_WIDTH-1:0]        A_DOUT,
  output logic                         A_VALID,
  // port B: scan-out side
  input  logic                         B_EN,
  input  logic [ADDR_BITS-1:0]         B_ADDR,
  output logic [DATA_WIDTH-1:0]        B_DOUT,
  output logic                         B_VALID,
  // fill engine
  input  logic                         CLEAR_REQ,
  input  logic [DATA_WIDTH-1:0]        CLEAR_VALUE,
  output logic                         BUSY
);

  localparam int unsigned BE_W      = DATA_WIDTH / 8;
  localparam int unsigned DEPTH     = 2 ** ADDR_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(DEPTH - 1);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

  state_e                  state_q, state_d;
  logic [ADDR_BITS-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   fill_q, fill_d;
  logic                    boot_q, boot_d;

  logic                    a_acc_c;
  logic                    mem_we_c;
  logic [ADDR_BITS-1:0]    mem_waddr_c;
  logic [DATA_WIDTH-1:0]   mem_wdata_c;
  logic [BE_W-1:0]         mem_wbe_c;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    a_valid1_q, b_valid1_q;
  logic [DATA_WIDTH-1:0]   a_dout1_q, b_dout1_q;

  assign BUSY    = (state_q == ST_CLEAR);
  assign A_READY = ~BUSY;
  assign a_acc_c = A_EN & A_READY;

  // Clear engine next-state and single shared write port arbitration
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fill_d      = fill_q;
    boot_d      = 1'b0;
    mem_we_c    = 1'b0;
    mem_waddr_c = A_ADDR;
    mem_wdata_c = A_DIN;
    mem_wbe_c   = A_BE;
    case (state_q)
      ST_IDLE: begin
        mem_we_c = a_acc_c & A_WE;
        // post-reset fill takes precedence over a same-edge software request
        if (boot_q) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          fill_d  = RESET_FILL;
        end else if (CLEAR_REQ) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
          fill_d  = CLEAR_VALUE;
        end
      end
      ST_CLEAR: begin
        mem_we_c    = 1'b1;
        mem_waddr_c = cnt_q;
        mem_wdata_c = fill_q;
        mem_wbe_c   = '1;
        if (cnt_q == LAST_ADDR) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + ADDR_BITS'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      fill_q  <= '0;
      boot_q  <= CLEAR_ON_RESET;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      fill_q  <= fill_d;
      boot_q  <= boot_d;
    end
  end

  // Array storage is deliberately not reset
  always_ff @(posedge CLK) begin
    if (mem_we_c) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (mem_wbe_c[i]) begin
          mem_q[mem_waddr_c][8*i +: 8] <= mem_wdata_c[8*i +: 8];
        end
      end
    end
  end

  // First read stage; non-blocking read of mem_q gives read-first collisions
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      a_valid1_q <= 1'b0;
      a_dout1_q  <= '0;
      b_valid1_q <= 1'b0;
      b_dout1_q  <= '0;
    end else begin
      a_valid1_q <= a_acc_c & ~A_WE;
      if (a_acc_c && !A_WE) begin
        a_dout1_q <= mem_q[A_ADDR];
      end
      b_valid1_q <= B_EN;
      if (B_EN) begin
        b_dout1_q <= mem_q[B_ADDR];
      end
    end
  end

`ifdef VRAM_DP_OUTREG_EN
  logic                    a_valid2_q, b_valid2_q;
  logic [DATA_WIDTH-1:0]   a_dout2_q, b_dout2_q;

  // Output stage: data advances only with its valid so DOUT holds between reads
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      a_valid2_q <= 1'b0;
      a_dout2_q  <= '0;
      b_valid2_q <= 1'b0;
      b_dout2_q  <= '0;
    end else begin
      a_valid2_q <= a_valid1_q;
      if (a_valid1_q) begin
        a_dout2_q <= a_dout1_q;
      end
      b_valid2_q <= b_valid1_q;
      if (b_valid1_q) begin
        b_dout2_q <= b_dout1_q;
      end
    end
  end

  assign A_VALID = a_valid2_q;
  assign A_DOUT  = a_dout2_q;
  assign B_VALID = b_valid2_q;
  assign B_DOUT  = b_dout2_q;
`else
  assign A_VALID = a_valid1_q;
  assign A_DOUT  = a_dout1_q;
  assign B_VALID = b_valid1_q;
  assign B_DOUT  = b_dout1_q;
`endif

endmodule
